// File: rtl/demux_lanes_pkg.sv
// Shared definitions for the demux_lanes receive-path lane demultiplexer.
//   - mode encodings (burst / word distribution)
//   - burst FSM state type
//   - next_enabled(): cyclic first-set search over a lane mask
package demux_lanes_pkg;

    localparam logic MODE_BURST = 1'b0;
    localparam logic MODE_WORD  = 1'b1;

    // Upper bound on the lane count; the search helper works on this fixed width.
    localparam int unsigned MAX_LANES = 16;

    typedef enum logic {StIdle, StBurst} state_e;

    // Returns the first set bit of mask at or after ptr, wrapping at lanes-1 -> 0.
    // Returns ptr unchanged when no lane below 'lanes' is set.
    function automatic logic [3:0] next_enabled(input logic [3:0]           ptr,
                                                input logic [MAX_LANES-1:0] mask,
                                                input int unsigned          lanes);
        logic [3:0]  res;
        logic        done;
        int unsigned idx;
        res  = ptr;
        done = 1'b0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < lanes) begin
                idx = {28'd0, ptr} + i;
                if (idx >= lanes) begin
                    idx = idx - lanes;
                end
                if (!done && mask[idx[3:0]]) begin
                    res  = idx[3:0];
                    done = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/demux_lanes_lane_rr_select.sv
// lane_rr_select: combinational round-robin lane picker.
//   ptr_i      starting lane of the cyclic search
//   lane_en_i  lane enable mask
//   eff_o      first enabled lane at or after ptr_i (wrapping)
//   found_o    at least one lane is enabled
module lane_rr_select
    import demux_lanes_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned PTR_W = $clog2(LANES)
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [LANES-1:0] lane_en_i,
    output logic [PTR_W-1:0] eff_o,
    output logic             found_o
);

    logic [MAX_LANES-1:0] mask_ext;
    logic [3:0]           ptr_ext;
    logic [3:0]           eff_ext;

    always_comb begin
        mask_ext = MAX_LANES'(lane_en_i);
        ptr_ext  = 4'(ptr_i);
        eff_ext  = next_enabled(ptr_ext, mask_ext, LANES);
        eff_o    = PTR_W'(eff_ext);
        found_o  = |lane_en_i;
    end

endmodule

// File: rtl/demux_lanes.sv
// demux_lanes: 1:LANES round-robin demultiplexer for the PHY receive path.
//   clk_2f     clock, rising edge
//   reset      asynchronous active-high reset
//   mode       0 = burst distribution, 1 = word distribution
//   lane_en    per-lane enable mask
//   data_in    input word, qualified by valid_in
//   data_out   registered lane data, lane i at [i*DATA_W +: DATA_W]
//   valid_out  registered per-lane valid (one-hot or zero)
//   lane_ptr   rotation pointer
//   drop_err   one-cycle pulse when a valid word had no enabled lane
module demux_lanes
    import demux_lanes_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      clk_2f,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [LANES-1:0]          lane_en,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      valid_in,
    output logic [LANES*DATA_W-1:0]   data_out,
    output logic [LANES-1:0]          valid_out,
    output logic [$clog2(LANES)-1:0]  lane_ptr,
    output logic                      drop_err
);

    localparam int unsigned PTR_W = $clog2(LANES);

    state_e                  state_q, state_d;
    logic [7:0]              burst_cnt_q, burst_cnt_d;
    logic [PTR_W-1:0]        burst_lane_q, burst_lane_d;
    logic [PTR_W-1:0]        lane_ptr_q, lane_ptr_d;
    logic [LANES*DATA_W-1:0] data_out_q, data_out_d;
    logic [LANES-1:0]        valid_out_q, valid_out_d;
    logic                    drop_err_q, drop_err_d;

    logic [PTR_W-1:0]        eff;
    logic                    eff_found;
    logic [PTR_W-1:0]        roll_ptr;
    logic [PTR_W-1:0]        roll_lane;
    logic                    roll_found;

    logic                    route_en;
    logic [PTR_W-1:0]        route_idx;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(LANES - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign roll_ptr = inc_ptr(burst_lane_q);

    lane_rr_select #(.LANES(LANES), .PTR_W(PTR_W)) u_sel_eff (
        .ptr_i     (lane_ptr_q),
        .lane_en_i (lane_en),
        .eff_o     (eff),
        .found_o   (eff_found)
    );

    // Lane that takes over when a burst hits the length cap.
    lane_rr_select #(.LANES(LANES), .PTR_W(PTR_W)) u_sel_roll (
        .ptr_i     (roll_ptr),
        .lane_en_i (lane_en),
        .eff_o     (roll_lane),
        .found_o   (roll_found)
    );

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        burst_lane_d = burst_lane_q;
        lane_ptr_d   = lane_ptr_q;
        drop_err_d   = 1'b0;
        route_en     = 1'b0;
        route_idx    = '0;

        if (valid_in && !eff_found) begin
            // No enabled lane anywhere: drop the word, leave all state alone.
            drop_err_d = 1'b1;
        end else if (mode == MODE_WORD) begin
            // Word mode also terminates any burst left open by a mode change.
            state_d     = StIdle;
            burst_cnt_d = '0;
            if (valid_in) begin
                route_en   = 1'b1;
                route_idx  = eff;
                lane_ptr_d = inc_ptr(eff);
            end else if (state_q == StBurst) begin
                lane_ptr_d = inc_ptr(burst_lane_q);
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        burst_lane_d = eff;
                        burst_cnt_d  = 8'd1;
                        state_d      = StBurst;
                        route_en     = 1'b1;
                        route_idx    = eff;
                    end
                end
                StBurst: begin
                    if (valid_in) begin
                        if (burst_cnt_q >= 8'(MAX_BURST) && roll_found) begin
                            burst_lane_d = roll_lane;
                            burst_cnt_d  = 8'd1;
                            lane_ptr_d   = inc_ptr(roll_lane);
                            route_en     = 1'b1;
                            route_idx    = roll_lane;
                        end else begin
                            // lane_en changes are ignored until the burst ends.
                            burst_cnt_d = burst_cnt_q + 8'd1;
                            route_en    = 1'b1;
                            route_idx   = burst_lane_q;
                        end
                    end else begin
                        lane_ptr_d  = inc_ptr(burst_lane_q);
                        burst_cnt_d = '0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        data_out_d  = '0;
        valid_out_d = '0;
        if (route_en) begin
            valid_out_d[route_idx]                 = 1'b1;
            data_out_d[route_idx*DATA_W +: DATA_W] = data_in;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            burst_cnt_q  <= '0;
            burst_lane_q <= '0;
            lane_ptr_q   <= '0;
            data_out_q   <= '0;
            valid_out_q  <= '0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_lane_q <= burst_lane_d;
            lane_ptr_q   <= lane_ptr_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign lane_ptr  = lane_ptr_q;
    assign drop_err  = drop_err_q;

endmodule

// File: doc/demux_lanes.md
# demux_lanes

Parametrised 1:N byte-lane demultiplexer for the PHY receive path, successor to the 1:2 valid-gated demux. Distributes a single valid-qualified word stream from the unstriping stage across LANES output lanes in round-robin order. Two distribution modes: per-word or per-burst. A lane-enable mask skips lanes, and a burst-length cap forces lane rotation. All outputs are registered.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- LANES, 4, output lane count (2..16)
- MAX_BURST, 4, maximum words per lane per burst in burst mode (1..255)

Ports:
- clk_2f  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- mode  in  1  0 = burst mode (rotate at end of burst), 1 = word mode (rotate every word)
- lane_en  in  LANES  per-lane enable mask; disabled lanes never receive data
- data_in  in  DATA_W  input word
- valid_in  in  1  data_in qualifier
- data_out  out  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
- valid_out  out  LANES  per-lane valid, one-hot or zero
- lane_ptr  out  $clog2(LANES)  current rotation pointer
- drop_err  out  1  one-cycle pulse when a valid word is dropped

## Operation
- Effective lane (eff) is the first enabled lane at or after lane_ptr, searched cyclically and wrapping at LANES-1 → 0.
- Word mode: each valid word goes to eff. lane_ptr ← (eff+1) mod LANES.
- Burst mode uses two states, IDLE and BURST.
  - IDLE + valid_in: latch burst_lane ← eff, route the word there, burst_cnt ← 1, go to BURST.
  - BURST + valid_in: route to burst_lane and increment burst_cnt. Changes to lane_en are ignored until the burst ends.
  - BURST + valid_in and burst_cnt = MAX_BURST (cap hit): the word starts a new burst on the next enabled lane after burst_lane. burst_cnt ← 1 and lane_ptr advances.
  - BURST + !valid_in: lane_ptr ← (burst_lane+1) mod LANES, go to IDLE.
- lane_en all zero with valid_in: word dropped, drop_err=1 next cycle, lane_ptr unchanged, no state change.
- Non-selected lanes: data_out slice = 0, valid_out bit = 0, every cycle.
- Changing mode while in BURST ends the burst: the word is treated as in IDLE/word mode.
- burst_cnt is 8 bits and never exceeds MAX_BURST.

## Timing
- Latency 1 cycle: a word sampled at edge k appears on data_out/valid_out after edge k.
- No backpressure; one word accepted per cycle; full throughput, with no gap cycle in word mode.
- lane_ptr updates on the same edge the word is registered.
- Reset (async, any time, including mid-burst): data_out=0, valid_out=0, lane_ptr=0, drop_err=0, state=IDLE, burst_cnt=0, burst_lane=0. The first post-reset word goes to the first enabled lane ≥ 0.
- Outputs are held at their reset values while reset is high, regardless of valid_in.

## Structure
- Shared package demux_lanes_pkg:
  - mode encodings MODE_BURST=0 and MODE_WORD=1
  - FSM state type (IDLE, BURST)
  - function next_enabled(ptr, mask) that returns the cyclic first-set index
- Sub-module lane_rr_select is combinational: given ptr and lane_en, it outputs eff and a found flag. It is instantiated twice, once for eff from lane_ptr and once for the next lane after burst_lane on cap rollover.
- Top level contains the FSM, counters and output registers.

## Test plan
Bench parameters LANES=4, DATA_W=8, MAX_BURST=4.
- Word mode, lane_en=4'b1111, words 0x10,0x11,0x12,0x13,0x14 back-to-back → lanes 0,1,2,3,0 each one cycle later; lane_ptr=1 at the end.
- Burst mode, lane_en=4'b1111: burst 0xA0..0xA2 (3 words), 1 idle cycle, then burst 0xB0 → 0xA0..0xA2 on lane 0 and 0xB0 on lane 1; lane_ptr=2 after the second burst ends.
- Burst mode, 6-word burst 0x00..0x05 → 0x00..0x03 on lane 0 and 0x04..0x05 on lane 1 (cap rollover); lane_ptr=2 after valid falls.
- Word mode, lane_en=4'b1010, 3 words 0x21,0x22,0x23 → lanes 1,3,1; lanes 0 and 2 valid never asserted. Then lane_en=0 with word 0x99 → no valid_out and one drop_err pulse.
- Assert reset mid-burst (after 2 words on lane 2) → all outputs zero asynchronously. After release, word 0x55 with lane_en=4'b1111 appears on lane 0.
- Burst mode: change lane_en from 4'b1111 to 4'b1110 mid-burst on lane 0 → the burst completes on lane 0. The next burst goes to lane 1.
